// File: rtl/key_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_counter_ctrl
// Brief    : Up/down/clear press counter with fixed key priority, rising-edge
//            key detection, long-press auto-repeat and modulo wrap flag.
// Revision : 1.0  initial release
// ============================================================================
module key_counter_ctrl #(
   parameter int WIDTH         = 8,
   parameter int HOLD_CYCLES   = 500,
   parameter int REPEAT_CYCLES = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_up,
   input  logic             key_down,
   input  logic             key_clr,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             repeat_active,
   output logic [1:0]       state
);

   // One timer serves both the hold and the repeat intervals.
   localparam int TIMER_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TIMER_W   = $clog2(TIMER_MAX);

   localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);
   localparam logic [WIDTH-1:0]   COUNT_MAX   = '1;
   localparam logic [WIDTH-1:0]   COUNT_ZERO  = '0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PRESS  = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_UP   = 2'd1,
      OWN_DOWN = 2'd2,
      OWN_CLR  = 2'd3
   } owner_t;

   state_t               state_q, state_d;
   owner_t               owner_q, owner_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [WIDTH-1:0]     count_q, count_d;
   logic                 wrap_q, wrap_d;
   logic                 repeat_active_q, repeat_active_d;
   logic                 key_up_q, key_down_q, key_clr_q;

   logic                 rise_up, rise_down, rise_clr;
   logic                 owner_level;
   logic                 step_en;
   owner_t               step_sel;

   assign rise_up   = key_up   & ~key_up_q;
   assign rise_down = key_down & ~key_down_q;
   assign rise_clr  = key_clr  & ~key_clr_q;

   // Current level of whichever key owns the FSM; no owner reads as released.
   always_comb begin
      owner_level = 1'b0;
      case (owner_q)
         OWN_UP:   owner_level = key_up;
         OWN_DOWN: owner_level = key_down;
         OWN_CLR:  owner_level = key_clr;
         default:  owner_level = 1'b0;
      endcase
   end

   // FSM next state, owner/timer update and step request.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      timer_d  = timer_q;
      step_en  = 1'b0;
      step_sel = owner_q;
      case (state_q)
         S_PRESS: begin
            if (!owner_level) begin
               state_d = S_IDLE;
               owner_d = OWN_NONE;
               timer_d = '0;
            end else if (timer_q == HOLD_LAST) begin
               // Clear never auto-repeats: timer parks at its terminal value.
               if (owner_q != OWN_CLR) begin
                  step_en = 1'b1;
                  timer_d = '0;
                  state_d = S_REPEAT;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_REPEAT: begin
            // Release takes precedence over a coinciding repeat expiry.
            if (!owner_level) begin
               state_d = S_IDLE;
               owner_d = OWN_NONE;
               timer_d = '0;
            end else if (timer_q == REPEAT_LAST) begin
               step_en = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            // IDLE, and the unused encoding which behaves as IDLE.
            state_d = S_IDLE;
            owner_d = OWN_NONE;
            timer_d = '0;
            if (rise_clr || rise_up || rise_down) begin
               if (rise_clr) begin
                  step_sel = OWN_CLR;
               end else if (rise_up) begin
                  step_sel = OWN_UP;
               end else begin
                  step_sel = OWN_DOWN;
               end
               step_en = 1'b1;
               owner_d = step_sel;
               state_d = S_PRESS;
            end
         end
      endcase
   end

   // Counter datapath: apply the selected step and flag modulo wrap.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (step_en) begin
         case (step_sel)
            OWN_UP: begin
               count_d = count_q + 1'b1;
               wrap_d  = (count_q == COUNT_MAX);
            end
            OWN_DOWN: begin
               count_d = count_q - 1'b1;
               wrap_d  = (count_q == COUNT_ZERO);
            end
            OWN_CLR: begin
               count_d = '0;
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
      repeat_active_d = (state_d == S_REPEAT);
   end

   // State, counter and key-history registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         owner_q         <= OWN_NONE;
         timer_q         <= '0;
         count_q         <= '0;
         wrap_q          <= 1'b0;
         repeat_active_q <= 1'b0;
         key_up_q        <= 1'b0;
         key_down_q      <= 1'b0;
         key_clr_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         timer_q         <= timer_d;
         count_q         <= count_d;
         wrap_q          <= wrap_d;
         repeat_active_q <= repeat_active_d;
         key_up_q        <= key_up;
         key_down_q      <= key_down;
         key_clr_q       <= key_clr;
      end
   end

   assign count         = count_q;
   assign wrap          = wrap_q;
   assign repeat_active = repeat_active_q;
   assign state         = state_q;

endmodule
`default_nettype wire
